// File: rtl/rst_req_gen.sv
// Reset-request generator: merges power-on, software and watchdog sources into one
// stretched rstreq, released only after a 4-phase req/ack handshake with the remote domain.
module rst_req_gen #(
    parameter int MINCYCLES  = 8,
    parameter int ACKTIMEOUT = 64,
    parameter int SYNCSTAGES = 2
) (
    input  logic       clk,
    input  logic       areset,
    input  logic       swreq,
    input  logic       wdtimeout,
    input  logic       rstack_async,
    input  logic       cause_clr,
    output logic       rstreq,
    output logic       busy,
    output logic [1:0] cause,
    output logic       ackerr
);
    localparam int CW = $clog2(ACKTIMEOUT + 1);
    localparam logic [CW-1:0] MIN_LAST = CW'(MINCYCLES - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(ACKTIMEOUT - 1);
    localparam logic [CW-1:0] TO_SAT   = CW'(ACKTIMEOUT);

    localparam logic [1:0] CAUSE_NONE = 2'b00;
    localparam logic [1:0] CAUSE_POR  = 2'b01;
    localparam logic [1:0] CAUSE_SW   = 2'b10;
    localparam logic [1:0] CAUSE_WDT  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_ASSERT  = 2'b01,
        ST_RELEASE = 2'b10
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         count_q, count_d;
    logic [1:0]            cause_q, cause_d;
    logic                  ackerr_q, ackerr_d;
    logic                  rstreq_q;
    logic                  busy_q;
    logic [SYNCSTAGES-1:0] ack_sync_q;
    logic                  ack_sync;

    // The acknowledge crosses from the remote domain; nothing else looks at rstack_async.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            ack_sync_q <= '0;
        end else begin
            ack_sync_q <= {ack_sync_q[SYNCSTAGES-2:0], rstack_async};
        end
    end

    assign ack_sync = ack_sync_q[SYNCSTAGES-1];

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        cause_d  = cause_q;
        ackerr_d = ackerr_q;

        // A cause loaded on ASSERT entry below overrides a simultaneous clear.
        if (cause_clr) begin
            cause_d = CAUSE_NONE;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (wdtimeout) begin
                    state_d = ST_ASSERT;
                    cause_d = CAUSE_WDT;
                end else if (swreq) begin
                    state_d = ST_ASSERT;
                    cause_d = CAUSE_SW;
                end
            end
            ST_ASSERT: begin
                if (count_q >= MIN_LAST && ack_sync) begin
                    state_d = ST_RELEASE;
                end else if (count_q == TO_LAST && !ack_sync) begin
                    state_d  = ST_RELEASE;
                    ackerr_d = 1'b1;
                end
            end
            ST_RELEASE: begin
                if (!ack_sync) begin
                    state_d = ST_IDLE;
                end else if (count_q == TO_LAST) begin
                    state_d  = ST_IDLE;
                    ackerr_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_ASSERT;
            end
        endcase

        if (state_d != state_q) begin
            count_d = '0;
        end else if (state_q != ST_IDLE && count_q != TO_SAT) begin
            count_d = count_q + CW'(1);
        end
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q  <= ST_ASSERT;
            count_q  <= '0;
            cause_q  <= CAUSE_POR;
            ackerr_q <= 1'b0;
            rstreq_q <= 1'b1;
            busy_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            cause_q  <= cause_d;
            ackerr_q <= ackerr_d;
            rstreq_q <= (state_d == ST_ASSERT);
            busy_q   <= (state_d != ST_IDLE);
        end
    end

    assign rstreq = rstreq_q;
    assign busy   = busy_q;
    assign cause  = cause_q;
    assign ackerr = ackerr_q;
endmodule

// File: tb/tb_rst_req_gen.sv
// Bench for rst_req_gen: directed and randomized handshake scenarios checked against
// pulse-length arithmetic derived from the min-time, timeout and synchronizer-delay rules.
module tb_rst_req_gen;
    localparam int MIN  = 8;
    localparam int TO   = 64;
    localparam int SYNC = 2;

    logic       clk;
    logic       areset;
    logic       swreq;
    logic       wdtimeout;
    logic       rstack_async;
    logic       cause_clr;
    logic       rstreq;
    logic       busy;
    logic [1:0] cause;
    logic       ackerr;

    int         n_assert;
    int         n_fail;
    logic       exp_ackerr;
    logic [1:0] exp_cause;

    rst_req_gen #(
        .MINCYCLES (MIN),
        .ACKTIMEOUT(TO),
        .SYNCSTAGES(SYNC)
    ) dut (
        .clk         (clk),
        .areset      (areset),
        .swreq       (swreq),
        .wdtimeout   (wdtimeout),
        .rstack_async(rstack_async),
        .cause_clr   (cause_clr),
        .rstreq      (rstreq),
        .busy        (busy),
        .cause       (cause),
        .ackerr      (ackerr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    // Remote acks d cycles after first seeing rstreq; ackSync then trails by SYNC cycles.
    function automatic int exp_assert_len(input bit never, input int d);
        int w;
        if (never) return TO;
        w = d + SYNC + 1;
        if (w < MIN) w = MIN;
        if (w > TO) w = TO;
        return w;
    endfunction

    // Remote drops ack d cycles after first seeing rstreq low.
    function automatic int exp_release_len(input bit never, input int d);
        if (never) return 1;
        return (d + SYNC + 1 < TO) ? d + SYNC + 1 : TO;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic measure_assert(input int d_ack, input bit never, input bit sw_mid, output int hi);
        hi = 1;
        for (int j = 0; j < 300; j++) begin
            if (!never && j == d_ack) rstack_async = 1'b1;
            swreq = sw_mid && (j == 1);
            @(negedge clk);
            if (rstreq !== 1'b1) break;
            hi++;
        end
        swreq = 1'b0;
    endtask

    task automatic measure_release(input int d_drop, output int rel);
        rel = 1;
        for (int k = 0; k < 300; k++) begin
            if (k == d_drop) rstack_async = 1'b0;
            @(negedge clk);
            if (busy !== 1'b1) break;
            rel++;
        end
    endtask

    // src: 0 software, 1 watchdog, 2 both in the same cycle.
    task automatic transaction(input int src, input int d_ack, input bit never, input int d_drop,
                               input bit sw_mid, input bit hold_wd);
        int hi;
        int rel;
        chk("pre_idle_busy", busy, 0);
        swreq     = (src != 1);
        wdtimeout = (src != 0);
        @(negedge clk);
        swreq = 1'b0;
        if (!hold_wd) wdtimeout = 1'b0;
        exp_cause = (src == 0) ? 2'b10 : 2'b11;
        chk("req_latency_rstreq", rstreq, 1);
        chk("entry_cause", cause, exp_cause);
        measure_assert(d_ack, never, sw_mid, hi);
        chk("assert_len", hi, exp_assert_len(never, d_ack));
        if (never) exp_ackerr = 1'b1;
        chk("release_busy", busy, 1);
        measure_release(d_drop, rel);
        chk("release_len", rel, exp_release_len(never, d_drop));
        if (!never && d_drop + SYNC + 1 > TO) exp_ackerr = 1'b1;
        chk("idle_rstreq", rstreq, 0);
        chk("ackerr", ackerr, exp_ackerr);
        chk("cause_hold", cause, exp_cause);
        if (rstack_async) begin
            rstack_async = 1'b0;
            repeat (SYNC + 1) @(negedge clk);
            chk("stuck_idle_busy", busy, 0);
        end
    endtask

    initial begin
        int hi;
        int rel;
        int src;
        int d_ack;
        int d_drop;
        bit never;

        n_assert     = 0;
        n_fail       = 0;
        areset       = 1'b1;
        swreq        = 1'b0;
        wdtimeout    = 1'b0;
        rstack_async = 1'b0;
        cause_clr    = 1'b0;
        exp_ackerr   = 1'b0;
        exp_cause    = 2'b01;

        // Power-on
        repeat (5) @(negedge clk);
        chk("por_rstreq", rstreq, 1);
        chk("por_busy", busy, 1);
        chk("por_cause", cause, 1);
        chk("por_ackerr", ackerr, 0);
        areset = 1'b0;
        measure_assert(3, 1'b0, 1'b0, hi);
        chk("por_assert_len", hi, exp_assert_len(1'b0, 3));
        measure_release(0, rel);
        chk("por_release_len", rel, SYNC + 1);
        chk("por_ackerr_after", ackerr, 0);
        chk("por_cause_after", cause, 1);

        // Software reset
        transaction(0, 2, 1'b0, 4, 1'b0, 1'b0);

        // Simultaneous sources, plus a swreq pulse mid-ASSERT that must be dropped
        transaction(2, 0, 1'b0, 1, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        chk("no_second_pulse", busy, 0);

        // Stuck ack
        transaction(0, 0, 1'b0, 1000, 1'b0, 1'b0);

        // Reset mid-RELEASE, asynchronous assertion
        swreq = 1'b1;
        @(negedge clk);
        swreq = 1'b0;
        chk("mid_rstreq_rise", rstreq, 1);
        measure_assert(0, 1'b0, 1'b0, hi);
        chk("mid_assert_len", hi, MIN);
        repeat (2) @(negedge clk);
        chk("mid_rel3_rstreq", rstreq, 0);
        chk("mid_rel3_busy", busy, 1);
        #2;
        areset       = 1'b1;
        rstack_async = 1'b0;
        #1;
        exp_ackerr = 1'b0;
        exp_cause  = 2'b01;
        chk("async_rstreq", rstreq, 1);
        chk("async_busy", busy, 1);
        chk("async_cause", cause, exp_cause);
        chk("async_ackerr", ackerr, exp_ackerr);
        repeat (2) @(negedge clk);
        areset = 1'b0;
        measure_assert(1, 1'b0, 1'b0, hi);
        chk("rerst_assert_len", hi, exp_assert_len(1'b0, 1));
        measure_release(0, rel);
        chk("rerst_release_len", rel, SYNC + 1);

        // cause_clr racing ASSERT entry, then a lone clear
        chk("race_pre_busy", busy, 0);
        swreq     = 1'b1;
        cause_clr = 1'b1;
        @(negedge clk);
        swreq     = 1'b0;
        cause_clr = 1'b0;
        chk("clr_race_cause", cause, 2);
        measure_assert(0, 1'b0, 1'b0, hi);
        chk("race_assert_len", hi, MIN);
        measure_release(0, rel);
        chk("race_release_len", rel, SYNC + 1);
        cause_clr = 1'b1;
        @(negedge clk);
        cause_clr = 1'b0;
        exp_cause = 2'b00;
        chk("clr_cause", cause, exp_cause);

        // Ack timeout, then a second request still works with ackerr sticky
        transaction(0, 0, 1'b1, 0, 1'b0, 1'b0);
        transaction(0, 1, 1'b0, 0, 1'b0, 1'b0);

        // Ack arriving on the last allowed ASSERT cycle
        transaction(0, TO - SYNC - 1, 1'b0, 0, 1'b0, 1'b0);

        // Watchdog still high on return to IDLE retriggers
        transaction(1, 0, 1'b0, 0, 1'b0, 1'b1);
        @(negedge clk);
        chk("wd_retrigger", rstreq, 1);
        wdtimeout = 1'b0;
        measure_assert(0, 1'b0, 1'b0, hi);
        chk("wd_re_assert_len", hi, MIN);
        measure_release(0, rel);
        chk("wd_re_release_len", rel, SYNC + 1);
        chk("wd_re_cause", cause, 3);

        // Randomized handshakes
        for (int i = 0; i < 12; i++) begin
            src    = int'($urandom_range(0, 2));
            never  = ($urandom_range(0, 5) == 0);
            d_ack  = int'($urandom_range(0, 58));
            d_drop = int'($urandom_range(0, 70));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            transaction(src, d_ack, never, d_drop, 1'b0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
